uart_modport: RTL and testbench

Full-duplex 8-bit UART block with a parallel-to-serial transmitter and a serial-to-parallel receiver. It sits between a byte-oriented producer/consumer and a serial link. TX takes a byte through a valid/ready handshake and serializes it at a fixed bit period. RX takes serial bits qualified by a per-bit strobe and presents each correctly framed byte with a one-cycle pulse.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx.sv | 95 +++++++++
 rtl/uart_modport.sv | 77 +++++++
 tb/tb_uart_modport.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8-bit UART: frame geometry and the
// TX/RX state encodings used by uart_tx and uart_modport.
package uart_pkg;

   localparam int DATA_W     = 8;
   localparam int FRAME_BITS = 10;

   // Index of the last data bit in a frame (D7), sized to the 4-bit bit index.
   localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

   // Both enums share a package scope, so literals carry a direction prefix.
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_DATA = 2'd1,
      RX_STOP = 2'd2
   } rx_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts out
// start, D0..D7 (LSB first) and stop, each held for CLKS_PER_BIT cycles.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic              valid_tx_in,
   input  logic [DATA_W-1:0] data_tx_in,
   output logic              ready_tx_out,
   output logic              sdata_tx_out
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        bit_idx;
   logic [DATA_W-1:0] shift;
   logic              bit_done;

   assign bit_done = (cnt == CNT_LAST);

   // Line and ready are registered and updated on the same edge as the state,
   // so each bit slot starts exactly at the edge that enters it.
   always_ff @(posedge clock) begin
      if (nreset) begin
         state        <= TX_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         ready_tx_out <= 1'b1;
         sdata_tx_out <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               if (valid_tx_in && ready_tx_out) begin
                  shift        <= data_tx_in;
                  cnt          <= '0;
                  ready_tx_out <= 1'b0;
                  sdata_tx_out <= 1'b0;
                  state        <= TX_START;
               end
            end

            TX_START: begin
               if (bit_done) begin
                  cnt          <= '0;
                  bit_idx      <= '0;
                  sdata_tx_out <= shift[0];
                  state        <= TX_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            TX_DATA: begin
               if (bit_done) begin
                  cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     sdata_tx_out <= 1'b1;
                     state        <= TX_STOP;
                  end else begin
                     bit_idx      <= bit_idx + 4'd1;
                     shift        <= shift >> 1;
                     sdata_tx_out <= shift[1];
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            TX_STOP: begin
               if (bit_done) begin
                  cnt          <= '0;
                  ready_tx_out <= 1'b1;
                  sdata_tx_out <= 1'b1;
                  state        <= TX_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               ready_tx_out <= 1'b1;
               sdata_tx_out <= 1'b1;
               state        <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_modport.sv
// Full-duplex 8-bit UART: instantiates the transmitter and implements the
// strobe-driven receiver inline. TX and RX share only clock and reset.
module uart_modport
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic              valid_tx_in,
   input  logic [DATA_W-1:0] data_tx_in,
   output logic              ready_tx_out,
   output logic              sdata_tx_out,
   input  logic              sdata_rx_in,
   input  logic              valid_rx_in,
   output logic [DATA_W-1:0] data_rx_out,
   output logic              ready_rx_out
);

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clock        (clock),
      .nreset       (nreset),
      .valid_tx_in  (valid_tx_in),
      .data_tx_in   (data_tx_in),
      .ready_tx_out (ready_tx_out),
      .sdata_tx_out (sdata_tx_out)
   );

   rx_state_t         rx_state;
   logic [3:0]        rx_bit_idx;
   logic [DATA_W-1:0] rx_shift;

   // The receiver moves only on strobed samples; a bad stop bit drops the byte
   // and returns to idle without treating that 0 as a new start bit.
   always_ff @(posedge clock) begin
      if (nreset) begin
         rx_state     <= RX_IDLE;
         rx_bit_idx   <= '0;
         data_rx_out  <= '0;
         ready_rx_out <= 1'b0;
      end else begin
         ready_rx_out <= 1'b0;
         if (valid_rx_in) begin
            case (rx_state)
               RX_IDLE: begin
                  if (!sdata_rx_in) begin
                     rx_bit_idx <= '0;
                     rx_state   <= RX_DATA;
                  end
               end

               RX_DATA: begin
                  rx_shift <= {sdata_rx_in, rx_shift[DATA_W-1:1]};
                  if (rx_bit_idx == LAST_BIT) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_bit_idx <= rx_bit_idx + 4'd1;
                  end
               end

               RX_STOP: begin
                  if (sdata_rx_in) begin
                     data_rx_out  <= rx_shift;
                     ready_rx_out <= 1'b1;
                  end
                  rx_state <= RX_IDLE;
               end

               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_modport.sv
// Directed bench for uart_modport with CLKS_PER_BIT = 4: reset, TX framing and
// back-to-back frames, RX good/framing-error frames, and mid-frame reset.
module tb_uart_modport;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       nreset;
   logic       valid_tx_in;
   logic [7:0] data_tx_in;
   logic       ready_tx_out;
   logic       sdata_tx_out;
   logic       sdata_rx_in;
   logic       valid_rx_in;
   logic [7:0] data_rx_out;
   logic       ready_rx_out;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int p0;

   uart_modport #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .valid_tx_in  (valid_tx_in),
      .data_tx_in   (data_tx_in),
      .ready_tx_out (ready_tx_out),
      .sdata_tx_out (sdata_tx_out),
      .sdata_rx_in  (sdata_rx_in),
      .valid_rx_in  (valid_rx_in),
      .data_rx_out  (data_rx_out),
      .ready_rx_out (ready_rx_out)
   );

   always #5 clock = ~clock;

   // Every cycle ready_rx_out is high counts once, so a stretched pulse shows up.
   always @(negedge clock) begin
      if (ready_rx_out === 1'b1) pulses++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called with the handshake edge just taken; checks all 10*CPB frame cycles
   // and the first idle cycle after them.
   task automatic tx_check(input logic [7:0] b, input string tag);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int j = 0; j < 10 * CPB; j++) begin
         @(negedge clock);
         chk({tag, " line"}, {7'd0, sdata_tx_out}, {7'd0, fr[j / CPB]});
         chk({tag, " busy"}, {7'd0, ready_tx_out}, 8'd0);
      end
      @(negedge clock);
      chk({tag, " ready after"}, {7'd0, ready_tx_out}, 8'd1);
      chk({tag, " idle line"},   {7'd0, sdata_tx_out}, 8'd1);
   endtask

   // One strobed sample, then gap cycles of unstrobed inverted noise.
   task automatic rx_bit(input logic b, input int gap);
      sdata_rx_in = b;
      valid_rx_in = 1'b1;
      @(negedge clock);
      valid_rx_in = 1'b0;
      sdata_rx_in = ~b;
      repeat (gap) @(negedge clock);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
      rx_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) rx_bit(b[i], i % 3);
      rx_bit(stop_bit, 2);
   endtask

   initial begin
      nreset      = 1'b1;
      valid_tx_in = 1'b0;
      data_tx_in  = 8'h00;
      sdata_rx_in = 1'b1;
      valid_rx_in = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      nreset = 1'b0;
      @(negedge clock);
      chk("rst ready_tx", {7'd0, ready_tx_out}, 8'd1);
      chk("rst sdata_tx", {7'd0, sdata_tx_out}, 8'd1);
      chk("rst ready_rx", {7'd0, ready_rx_out}, 8'd0);
      chk("rst data_rx",  data_rx_out,          8'h00);

      // Single TX byte A5: 0,1,0,1,0,0,1,0,1,1
      valid_tx_in = 1'b1;
      data_tx_in  = 8'hA5;
      @(posedge clock);
      #1 valid_tx_in = 1'b0;
      tx_check(8'hA5, "txA5");

      // Back-to-back 00 then FF with valid held; data changes mid-frame 1
      valid_tx_in = 1'b1;
      data_tx_in  = 8'h00;
      @(posedge clock);
      #1 data_tx_in = 8'hFF;
      tx_check(8'h00, "tx00");
      @(posedge clock);
      #1 valid_tx_in = 1'b0;
      tx_check(8'hFF, "txFF");

      // RX good frame 3C with idle strobed 1s ahead of it
      p0 = pulses;
      rx_bit(1'b1, 1);
      rx_bit(1'b1, 0);
      rx_frame(8'h3C, 1'b1);
      repeat (3) @(negedge clock);
      chk("rx3C pulses",  8'(pulses - p0), 8'd1);
      chk("rx3C data",    data_rx_out,     8'h3C);
      chk("rx3C pulse low", {7'd0, ready_rx_out}, 8'd0);

      // Framing error on 55, then good 81 immediately after
      p0 = pulses;
      rx_frame(8'h55, 1'b0);
      repeat (2) @(negedge clock);
      chk("rx55 no pulse", 8'(pulses - p0), 8'd0);
      chk("rx55 data held", data_rx_out,    8'h3C);
      rx_frame(8'h81, 1'b1);
      repeat (2) @(negedge clock);
      chk("rx81 pulses", 8'(pulses - p0), 8'd1);
      chk("rx81 data",   data_rx_out,     8'h81);

      // Reset in the middle of a TX frame and an RX frame (before D3)
      valid_tx_in = 1'b1;
      data_tx_in  = 8'hC3;
      @(posedge clock);
      #1 valid_tx_in = 1'b0;
      @(negedge clock);
      rx_bit(1'b0, 0);
      rx_bit(1'b0, 0);
      rx_bit(1'b1, 0);
      rx_bit(1'b1, 0);
      repeat (6) @(negedge clock);
      chk("mid tx busy", {7'd0, ready_tx_out}, 8'd0);
      p0 = pulses;
      nreset = 1'b1;
      @(negedge clock);
      chk("mid rst sdata_tx", {7'd0, sdata_tx_out}, 8'd1);
      chk("mid rst ready_tx", {7'd0, ready_tx_out}, 8'd1);
      chk("mid rst ready_rx", {7'd0, ready_rx_out}, 8'd0);
      chk("mid rst data_rx",  data_rx_out,          8'h00);
      nreset = 1'b0;
      @(negedge clock);
      chk("mid rst no pulse", 8'(pulses - p0), 8'd0);

      // Fresh frames after the abort
      rx_frame(8'hE7, 1'b1);
      repeat (2) @(negedge clock);
      chk("rxE7 pulses", 8'(pulses - p0), 8'd1);
      chk("rxE7 data",   data_rx_out,     8'hE7);
      valid_tx_in = 1'b1;
      data_tx_in  = 8'h3C;
      @(posedge clock);
      #1 valid_tx_in = 1'b0;
      tx_check(8'h3C, "tx3C");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
